// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//
// Owns the single register-file write port. The writeback stream is the
// primary writer; an auxiliary multi-cycle unit (mul/div) is the secondary
// writer and holds its request until it sees a one-cycle aux_gnt pulse.
// Also holds the architectural OUT port register.
//
// Optional feature macro: STARVE_GUARD_EN
//   defined   : a wait counter bounds how many writeback wins an aux request
//               can suffer (MAX_WAIT). When the bound is reached the pipeline
//               is frozen for one cycle (stall_req) and aux wins.
//   undefined : no counter, no FORCE state; aux waits for an idle writeback
//               slot and stall_req is tied 0. MAX_WAIT does not exist.
//
// Parameters
//   DATA_W    register / port data width
//   REG_AW    register address width
//   MAX_WAIT  aux wait cycles before a stall is forced, 1..15 (guard only)
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   async active-low reset (released synchronously inside)
//   wb_valid   in   writeback slot carries a register write
//   wb_rdst    in   writeback destination
//   wb_data    in   writeback value
//   wb_out_en  in   writeback slot is an OUT instruction
//   aux_req    in   aux write request, held with aux_rdst/aux_data until grant
//   aux_rdst   in   aux destination
//   aux_data   in   aux value
//   aux_gnt    out  one-cycle pulse: aux write performed this cycle
//   stall_req  out  pipeline must freeze; WB slot replayed next cycle
//   rf_we      out  register-file write enable
//   rf_waddr   out  register-file write address
//   rf_wdata   out  register-file write data
//   out_port   out  OUT port register
//
// All outputs are registered: a request that wins in cycle N shows up on
// rf_* / aux_gnt in cycle N+1.
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
`ifdef STARVE_GUARD_EN
  ,
  parameter int MAX_WAIT = 4
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rdst,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              wb_out_en,
  input  logic              aux_req,
  input  logic [REG_AW-1:0] aux_rdst,
  input  logic [DATA_W-1:0] aux_data,
  output logic              aux_gnt,
  output logic              stall_req,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [DATA_W-1:0] out_port
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    GRANT = 2'd2
`ifdef STARVE_GUARD_EN
    ,
    FORCE = 2'd3
`endif
  } arbState_e;

  logic [1:0]        rstSync_q;
  arbState_e         state_q, state_d;
  logic              rfWe_q, rfWe_d;
  logic [REG_AW-1:0] rfWaddr_q, rfWaddr_d;
  logic [DATA_W-1:0] rfWdata_q, rfWdata_d;
  logic [DATA_W-1:0] outPort_q, outPort_d;
  logic              auxGnt_q, auxGnt_d;
  logic              takeAux;
  logic              takeWb;
  logic              slotIgnored;
`ifdef STARVE_GUARD_EN
  logic [3:0]        waitCnt_q, waitCnt_d;
  logic [3:0]        waitInc;
  logic              stall_q, stall_d;
`endif

  // Reset release synchroniser: assertion is immediate through the async
  // clear, release takes two clock edges so every state flop leaves reset
  // on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstSync_q <= 2'b00;
    end else begin
      rstSync_q <= {rstSync_q[0], 1'b1};
    end
  end

  // Arbitration decision and next-state logic. IDLE and GRANT decide the
  // same way: an aux_req seen while aux_gnt is showing is a new request.
  always_comb begin
    state_d     = state_q;
    takeAux     = 1'b0;
    takeWb      = 1'b0;
    slotIgnored = 1'b0;
`ifdef STARVE_GUARD_EN
    waitCnt_d   = waitCnt_q;
    stall_d     = 1'b0;
    waitInc     = (waitCnt_q < 4'(MAX_WAIT)) ? waitCnt_q + 4'd1 : waitCnt_q;
`endif

    unique case (state_q)
      IDLE, GRANT: begin
        if (aux_req && !wb_valid) begin
          takeAux = 1'b1;
          state_d = GRANT;
        end else if (aux_req) begin
          takeWb  = 1'b1;
          state_d = WAIT;
`ifdef STARVE_GUARD_EN
          waitCnt_d = 4'd1;
`endif
        end else begin
          takeWb  = wb_valid;
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (!aux_req) begin
          // Aux abandoned its request: drop it, writeback proceeds normally.
          takeWb  = wb_valid;
          state_d = IDLE;
        end else if (!wb_valid) begin
          takeAux = 1'b1;
          state_d = GRANT;
        end else begin
          takeWb  = 1'b1;
          state_d = WAIT;
`ifdef STARVE_GUARD_EN
          waitCnt_d = waitInc;
`endif
        end
      end
`ifdef STARVE_GUARD_EN
      FORCE: begin
        // Pipeline is frozen this cycle, so the writeback slot is not
        // consumed; it will be presented again next cycle.
        slotIgnored = 1'b1;
        if (aux_req) begin
          takeAux = 1'b1;
          state_d = GRANT;
        end else begin
          state_d = IDLE;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef STARVE_GUARD_EN
    // Counter only lives while aux is waiting; the bound check covers both
    // the first loss (from IDLE/GRANT) and later losses (in WAIT).
    if (state_d == IDLE || state_d == GRANT) begin
      waitCnt_d = 4'd0;
    end
    if (state_d == WAIT && waitCnt_d == 4'(MAX_WAIT)) begin
      state_d = FORCE;
      stall_d = 1'b1;
    end
`endif

    rfWe_d    = takeAux | takeWb;
    auxGnt_d  = takeAux;
    rfWaddr_d = '0;
    rfWdata_d = '0;
    if (takeAux) begin
      rfWaddr_d = aux_rdst;
      rfWdata_d = aux_data;
    end else if (takeWb) begin
      rfWaddr_d = wb_rdst;
      rfWdata_d = wb_data;
    end

    outPort_d = outPort_q;
    if (wb_out_en && !slotIgnored) begin
      outPort_d = wb_data;
    end

    // Hold everything at reset values until the synchronised release.
    if (!rstSync_q[1]) begin
      state_d   = IDLE;
      rfWe_d    = 1'b0;
      auxGnt_d  = 1'b0;
      rfWaddr_d = '0;
      rfWdata_d = '0;
      outPort_d = '0;
`ifdef STARVE_GUARD_EN
      waitCnt_d = 4'd0;
      stall_d   = 1'b0;
`endif
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rfWe_q    <= 1'b0;
      rfWaddr_q <= '0;
      rfWdata_q <= '0;
      outPort_q <= '0;
      auxGnt_q  <= 1'b0;
`ifdef STARVE_GUARD_EN
      waitCnt_q <= 4'd0;
      stall_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rfWe_q    <= rfWe_d;
      rfWaddr_q <= rfWaddr_d;
      rfWdata_q <= rfWdata_d;
      outPort_q <= outPort_d;
      auxGnt_q  <= auxGnt_d;
`ifdef STARVE_GUARD_EN
      waitCnt_q <= waitCnt_d;
      stall_q   <= stall_d;
`endif
    end
  end

  assign rf_we    = rfWe_q;
  assign rf_waddr = rfWaddr_q;
  assign rf_wdata = rfWdata_q;
  assign out_port = outPort_q;
  assign aux_gnt  = auxGnt_q;
`ifdef STARVE_GUARD_EN
  assign stall_req = stall_q;
`else
  assign stall_req = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_write_arbiter
//
// Scoreboard bench for regfile_write_arbiter. Inputs are driven on the
// falling edge; a behavioural model decides what the arbiter must do with
// that cycle's inputs and queues the expected result. A monitor sampling
// just after each rising edge pops and compares. Honours STARVE_GUARD_EN
// in the same way as the design.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_regfile_write_arbiter;

  localparam int DATA_W   = 16;
  localparam int REG_AW   = 3;
  localparam int MAX_WAIT = 4;
`ifdef STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              gnt;
  } wrExp_t;

  typedef struct packed {
    logic              we;
    logic              stall;
    logic [DATA_W-1:0] outp;
  } cycExp_t;

  logic              clk;
  logic              rst_n;
  logic              wb_valid;
  logic [REG_AW-1:0] wb_rdst;
  logic [DATA_W-1:0] wb_data;
  logic              wb_out_en;
  logic              aux_req;
  logic [REG_AW-1:0] aux_rdst;
  logic [DATA_W-1:0] aux_data;
  logic              aux_gnt;
  logic              stall_req;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] out_port;

  wrExp_t  writeQ[$];
  cycExp_t cycleQ[$];
  int      checks;
  int      failures;
  logic    monOn;

  int                waiting;
  logic              forceNow;
  logic              grantPending;
  logic              slotIgnored;
  logic [DATA_W-1:0] expOut;

  logic              reqActive;
  logic [REG_AW-1:0] reqR;
  logic [DATA_W-1:0] reqD;

  regfile_write_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_valid  (wb_valid),
    .wb_rdst   (wb_rdst),
    .wb_data   (wb_data),
    .wb_out_en (wb_out_en),
    .aux_req   (aux_req),
    .aux_rdst  (aux_rdst),
    .aux_data  (aux_data),
    .aux_gnt   (aux_gnt),
    .stall_req (stall_req),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .out_port  (out_port)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one cycle of inputs and predicts the arbiter's response from the
  // sharing rules: writeback wins unless the cycle is a forced stall; an
  // idle writeback slot lets aux in; with the guard, the MAX_WAIT-th
  // consecutive loss freezes the pipeline for one cycle in which aux wins.
  task automatic applyStimulus(input logic wbV, input logic [REG_AW-1:0] wbR,
                               input logic [DATA_W-1:0] wbD, input logic oe,
                               input logic aReq, input logic [REG_AW-1:0] aR,
                               input logic [DATA_W-1:0] aD);
    wrExp_t  w;
    cycExp_t c;
    logic    nextForce;
    wb_valid  = wbV;
    wb_rdst   = wbR;
    wb_data   = wbD;
    wb_out_en = oe;
    aux_req   = aReq;
    aux_rdst  = aR;
    aux_data  = aD;
    c.we         = 1'b0;
    nextForce    = 1'b0;
    grantPending = 1'b0;
    slotIgnored  = forceNow;
    if (forceNow || (aReq && !wbV)) begin
      if (aReq) begin
        w.addr = aR; w.data = aD; w.gnt = 1'b1;
        writeQ.push_back(w);
        c.we = 1'b1;
        grantPending = 1'b1;
      end
      waiting = 0;
    end else if (aReq) begin
      w.addr = wbR; w.data = wbD; w.gnt = 1'b0;
      writeQ.push_back(w);
      c.we = 1'b1;
      if (waiting < MAX_WAIT) waiting++;
      nextForce = GUARD && (waiting == MAX_WAIT);
    end else begin
      if (wbV) begin
        w.addr = wbR; w.data = wbD; w.gnt = 1'b0;
        writeQ.push_back(w);
        c.we = 1'b1;
      end
      waiting = 0;
    end
    if (oe && !slotIgnored) expOut = wbD;
    c.stall = nextForce;
    c.outp  = expOut;
    cycleQ.push_back(c);
    forceNow = nextForce;
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    end
  endtask

  // Writeback traffic every cycle while aux holds its request; a slot
  // frozen by a stall is presented again on the following cycle.
  task automatic trafficWithAux(input int n, input logic [DATA_W-1:0] base);
    int k;
    k = 0;
    for (int i = 0; i < n; i++) begin
      if (grantPending) reqActive = 1'b0;
      if (!slotIgnored) k++;
      applyStimulus(1'b1, k[REG_AW-1:0], base + DATA_W'(k), 1'b0, reqActive, reqR, reqD);
    end
  endtask

  task automatic drainAux(input int n);
    for (int i = 0; i < n; i++) begin
      if (grantPending) reqActive = 1'b0;
      applyStimulus(1'b0, '0, '0, 1'b0, reqActive, reqR, reqD);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " rf_we"},     32'(rf_we),     32'd0);
    checkOutput({tag, " rf_waddr"},  32'(rf_waddr),  32'd0);
    checkOutput({tag, " rf_wdata"},  32'(rf_wdata),  32'd0);
    checkOutput({tag, " aux_gnt"},   32'(aux_gnt),   32'd0);
    checkOutput({tag, " stall_req"}, 32'(stall_req), 32'd0);
    checkOutput({tag, " out_port"},  32'(out_port),  32'd0);
  endtask

  task automatic resetModel();
    writeQ.delete();
    cycleQ.delete();
    waiting      = 0;
    forceNow     = 1'b0;
    grantPending = 1'b0;
    slotIgnored  = 1'b0;
    expOut       = '0;
  endtask

  // Monitor: one cycle record per rising edge, one write record per write
  // the DUT presents.
  cycExp_t monC;
  wrExp_t  monW;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (monOn) begin
        if (cycleQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL cycle record: got empty scoreboard, expected an entry");
        end else begin
          monC = cycleQ.pop_front();
          checkOutput("rf_we", 32'(rf_we), 32'(monC.we));
          checkOutput("stall_req", 32'(stall_req), 32'(monC.stall));
          checkOutput("out_port", 32'(out_port), 32'(monC.outp));
          if (rf_we === 1'b1 && writeQ.size() != 0) begin
            monW = writeQ.pop_front();
            checkOutput("rf_waddr", 32'(rf_waddr), 32'(monW.addr));
            checkOutput("rf_wdata", 32'(rf_wdata), 32'(monW.data));
            checkOutput("aux_gnt", 32'(aux_gnt), 32'(monW.gnt));
          end else begin
            checkOutput("aux_gnt without write", 32'(aux_gnt), 32'd0);
          end
        end
      end
    end
  end

  // Main sequence: reset, directed cases, mid-write reset, random traffic.
  initial begin
    checks    = 0;
    failures  = 0;
    monOn     = 1'b0;
    reqActive = 1'b0;
    reqR      = '0;
    reqD      = '0;
    resetModel();
    rst_n     = 1'b0;
    wb_valid  = 1'b0;
    wb_rdst   = '0;
    wb_data   = '0;
    wb_out_en = 1'b0;
    aux_req   = 1'b0;
    aux_rdst  = '0;
    aux_data  = '0;

    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    monOn = 1'b1;

    $display("[TB] wb only, idle grant, OUT port");
    applyStimulus(1'b1, 3'd3, 16'hBEEF, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 3'd5, 16'h1234);
    idleCycles(1);
    applyStimulus(1'b0, '0, 16'h00A5, 1'b1, 1'b0, '0, '0);
    idleCycles(3);
    applyStimulus(1'b1, 3'd1, 16'h7777, 1'b1, 1'b0, '0, '0);

    $display("[TB] starvation");
    reqActive = 1'b1; reqR = 3'd2; reqD = 16'hA0A0;
    trafficWithAux(10, 16'h1000);
    drainAux(4);

    $display("[TB] abort then fresh request");
    reqActive = 1'b1; reqR = 3'd4; reqD = 16'h0BAD;
    trafficWithAux(2, 16'h2000);
    reqActive = 1'b0;
    trafficWithAux(2, 16'h2100);
    idleCycles(2);
    reqActive = 1'b1; reqR = 3'd4; reqD = 16'h0C0C;
    trafficWithAux(6, 16'h2200);
    drainAux(4);

    $display("[TB] reset during a write with aux pending");
    reqActive = 1'b1; reqR = 3'd7; reqD = 16'h5A5A;
    applyStimulus(1'b1, 3'd6, 16'hC0DE, 1'b1, reqActive, reqR, reqD);
    monOn = 1'b0;
    rst_n = 1'b0;
    #1;
    checkAllZero("mid reset");
    resetModel();
    wb_valid = 1'b0; wb_out_en = 1'b0; aux_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    monOn = 1'b1;
    drainAux(3);

    $display("[TB] random traffic");
    begin
      logic              sV, sOe;
      logic [REG_AW-1:0] sR;
      logic [DATA_W-1:0] sD;
      sV = 1'b0; sOe = 1'b0; sR = '0; sD = '0;
      for (int n = 0; n < 400; n++) begin
        if (grantPending) reqActive = 1'b0;
        else if (reqActive && $urandom_range(99) < 5) reqActive = 1'b0;
        if (!reqActive && $urandom_range(99) < 35) begin
          reqActive = 1'b1;
          reqR = REG_AW'($urandom);
          reqD = DATA_W'($urandom);
        end
        if (!slotIgnored) begin
          sV  = ($urandom_range(99) < 70);
          sOe = ($urandom_range(99) < 20);
          sR  = REG_AW'($urandom);
          sD  = DATA_W'($urandom);
        end
        applyStimulus(sV, sR, sD, sOe, reqActive, reqR, reqD);
      end
    end
    drainAux(4);
    idleCycles(2);
    monOn = 1'b0;

    checkOutput("writes left unseen", 32'(writeQ.size()), 32'd0);
    checkOutput("cycles left unseen", 32'(cycleQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
